// File: rtl/inmem_arb_pkg.sv
// Shared types and default sizes for the inmem read-port arbiter.
package inmem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ  = 3;   // 0 = packet builder, 1 = DI checker, 2 = CRC checker
  localparam int unsigned DEF_ADDR_W   = 14;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_LOCK_MAX = 64;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/inmem_rd_arbiter_rr_pick.sv
// Round-robin winner selection: first set request at or after rr_ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  // Scan every requester in priority order starting at the pointer.
  always_comb begin : p_scan
    int unsigned idx;
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[idx]) begin
        winner_o = IDX_W'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inmem_rd_arbiter.sv
// Arbitrates the inmem port-B read path between NUM_REQ requesters.
// A granted owner keeps the port while it holds lock; the read data
// returns one cycle after each mem_en beat, steered by rvalid.
// Optional macro ARB_LOCK_TIMEOUT_EN: force-release an owner after
// LOCK_MAX cycles in OWNED and pulse lock_err.
module inmem_rd_arbiter
  import inmem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data_i,
  output logic                      busy,
  output logic                      lock_err
);

  localparam int unsigned     IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || LOCK_MAX < 2) begin : g_bad_cfg
    $error("inmem_rd_arbiter: NUM_REQ and LOCK_MAX must both be at least 2");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   pick_idx, next_ptr;
  logic               pick_vld;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d, owner_oh;
  logic [ADDR_W-1:0]  owner_addr;
  logic               own_req, own_lock, timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

  // Decode the current owner: one-hot form, its req/lock bits and address slice.
  always_comb begin
    owner_oh   = '0;
    own_req    = 1'b0;
    own_lock   = 1'b0;
    owner_addr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_oh[k] = 1'b1;
        own_req     = req[k];
        own_lock    = lock[k];
        owner_addr  = addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  // Next-state and port outputs; everything reads as zero while reset is high.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rvalid_d = '0;
    gnt      = '0;
    mem_en   = 1'b0;
    mem_addr = '0;
    busy     = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            owner_d = pick_idx;
            state_d = ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          gnt  = owner_oh;
          busy = 1'b1;
          if (own_req) begin
            mem_en   = 1'b1;
            mem_addr = owner_addr;
            rvalid_d = owner_oh;
          end
          // Dropped request, final unlocked beat, or forced release.
          if (!own_req || !own_lock || timeout) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_ptr;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // FSM state, owner, round-robin pointer and the one-beat read-valid pipeline.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid = reset ? '0 : rvalid_q;
  assign rdata  = (|rvalid) ? mem_data_i : '0;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_err_q;

  assign timeout = (state_q == ARB_OWNED) && own_req && own_lock &&
                   (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  // Count consecutive OWNED cycles; restart from zero for every new owner.
  always_comb begin
    lock_cnt_d = '0;
    if (state_q == ARB_OWNED && state_d == ARB_OWNED) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
  end

  // Hold the counter and register the forced-release pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= timeout;
    end
  end

  assign lock_err = reset ? 1'b0 : lock_err_q;
`else
  // A lock is honoured indefinitely.
  assign timeout  = 1'b0;
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_inmem_rd_arbiter.sv
// Self-checking bench for inmem_rd_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_inmem_rd_arbiter;

  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 32;
`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int LM    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int LM    = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req, lock, gnt, rvalid;
  logic [NR*AW-1:0] addr_i;
  logic [DW-1:0]  rdata, mem_data_i;
  logic           mem_en, busy, lock_err;
  logic [AW-1:0]  mem_addr;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  inmem_rd_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LOCK_MAX (LM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .addr_i     (addr_i),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_data_i (mem_data_i),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  task automatic idle_inputs();
    req        = '0;
    lock       = '0;
    addr_i     = '0;
    mem_data_i = '0;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] v);
    addr_i[k*AW +: AW] = v;
  endtask

  // One reset edge; returns at a falling edge with reset low and the DUT idle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req        = '1;
    lock       = '1;
    addr_i     = '1;
    mem_data_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({gnt, rvalid, mem_en, mem_addr, busy, lock_err} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got gnt=%b rvalid=%b en=%b addr=%h busy=%b err=%b want all 0",
               gnt, rvalid, mem_en, mem_addr, busy, lock_err);
    end
    n_chk++;
    if (rdata !== '0) begin
      n_err++;
      $display("FAIL reset rdata: got %h want 0", rdata);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    do_reset();
    req = 3'b010;
    set_addr(0, 14'h1111);
    set_addr(1, 14'h0040);
    set_addr(2, 14'h2222);
    #1;
    n_chk++;
    if (gnt !== 3'b000) begin n_err++; $display("FAIL single gnt c0: got %b want 000", gnt); end
    @(negedge clk); #1;
    n_chk++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL single gnt c1: got %b want 010", gnt); end
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 14'h0040) begin
      n_err++; $display("FAIL single read c1: got en=%b addr=%h want en=1 addr=0040", mem_en, mem_addr);
    end
    @(negedge clk);
    req = '0;
    d = $urandom;
    mem_data_i = d;
    #1;
    n_chk++;
    if (rvalid !== 3'b010 || rdata !== d) begin
      n_err++; $display("FAIL single return c2: got rvalid=%b rdata=%h want 010 %h", rvalid, rdata, d);
    end
    n_chk++;
    if (gnt !== 3'b000) begin n_err++; $display("FAIL single gnt c2: got %b want 000", gnt); end
    @(negedge clk);
    mem_data_i = $urandom;
    #1;
    n_chk++;
    if (rvalid !== 3'b000 || rdata !== '0) begin
      n_err++; $display("FAIL single quiet c3: got rvalid=%b rdata=%h want 000 0", rvalid, rdata);
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_g [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    req  = 3'b111;
    lock = 3'b000;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_chk++;
      if (gnt !== exp_g[c] || mem_en !== (exp_g[c] != 0)) begin
        n_err++;
        $display("FAIL contention c%0d: got gnt=%b en=%b want gnt=%b en=%b",
                 c, gnt, mem_en, exp_g[c], (exp_g[c] != 0));
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic test_burst();
    logic [NR-1:0] gnt_t [9] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};
    logic [NR-1:0] rv_t  [9] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    logic [AW-1:0] exp_a;
    logic [DW-1:0] d;
    int beats = 0;
    do_reset();
    set_addr(2, 14'h02AB);
    for (int c = 0; c < 9; c++) begin
      req  = (c < 7) ? 3'b101 : 3'b100;
      lock = (c < 6) ? 3'b001 : 3'b000;
      set_addr(0, AW'(14'h0100 + c));
      d = $urandom;
      mem_data_i = d;
      #1;
      exp_a = (c >= 1 && c <= 6) ? AW'(14'h0100 + c) : (c == 8) ? 14'h02AB : '0;
      n_chk++;
      if (gnt !== gnt_t[c] || mem_en !== (gnt_t[c] != 0) || mem_addr !== exp_a) begin
        n_err++;
        $display("FAIL burst c%0d: got gnt=%b en=%b addr=%h want gnt=%b en=%b addr=%h",
                 c, gnt, mem_en, mem_addr, gnt_t[c], (gnt_t[c] != 0), exp_a);
      end
      n_chk++;
      if (rvalid !== rv_t[c] || rdata !== ((rv_t[c] != 0) ? d : '0)) begin
        n_err++;
        $display("FAIL burst return c%0d: got rvalid=%b rdata=%h want rvalid=%b", c, rvalid, rdata, rv_t[c]);
      end
      if (c <= 7 && mem_en === 1'b1) beats++;
      @(negedge clk);
    end
    n_chk++;
    if (beats !== 6) begin n_err++; $display("FAIL burst beats: got %0d want 6", beats); end
    idle_inputs();
  endtask

`ifdef ARB_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    logic [NR-1:0] exp_g;
    logic          exp_e;
    do_reset();
    req  = 3'b110;
    lock = 3'b010;
    for (int c = 0; c < 11; c++) begin
      #1;
      exp_g = (c >= 1 && c <= 8) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000;
      exp_e = (c == 9);
      n_chk++;
      if (gnt !== exp_g || mem_en !== (exp_g != 0) || lock_err !== exp_e) begin
        n_err++;
        $display("FAIL timeout c%0d: got gnt=%b en=%b err=%b want gnt=%b en=%b err=%b",
                 c, gnt, mem_en, lock_err, exp_g, (exp_g != 0), exp_e);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask
`else
  task automatic test_lock_hold();
    int held = 0;
    int errs = 0;
    do_reset();
    req  = 3'b110;
    lock = 3'b010;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (c >= 1 && gnt === 3'b010 && mem_en === 1'b1) held++;
      if (lock_err !== 1'b0) errs++;
      @(negedge clk);
    end
    n_chk++;
    if (held !== 29) begin n_err++; $display("FAIL lock hold cycles: got %0d want 29", held); end
    n_chk++;
    if (errs !== 0) begin n_err++; $display("FAIL lock hold lock_err: got %0d pulses want 0", errs); end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    req  = 3'b010;
    lock = 3'b010;
    set_addr(1, 14'h0333);
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (mem_en !== 1'b1 || gnt !== 3'b010) begin
      n_err++; $display("FAIL midrst beat3: got en=%b gnt=%b want en=1 gnt=010", mem_en, gnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b111;
    lock  = 3'b000;
    #1;
    n_chk++;
    if (gnt !== 3'b000 || rvalid !== 3'b000 || mem_en !== 1'b0) begin
      n_err++; $display("FAIL midrst after: got gnt=%b rvalid=%b en=%b want 000 000 0", gnt, rvalid, mem_en);
    end
    @(negedge clk); #1;
    n_chk++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL midrst regrant: got %b want 001", gnt); end
    idle_inputs();
  endtask

  // Randomized traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int m_owner, m_rr, m_cnt, m_rv;
    bit m_err, held, to;
    logic [NR-1:0] e_gnt, e_rv;
    logic          e_en, e_busy, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd;
    do_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0; m_rv = -1; m_err = 1'b0;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        lock[k] = ($urandom_range(0, 9) < 7);
        set_addr(k, AW'($urandom));
      end
      mem_data_i = $urandom;
      #1;
      if (reset) begin
        e_gnt = '0; e_en = 1'b0; e_addr = '0; e_rv = '0; e_rd = '0; e_busy = 1'b0; e_err = 1'b0;
      end else begin
        e_gnt  = (m_owner >= 0) ? NR'(1) << m_owner : '0;
        e_en   = (m_owner >= 0) ? req[m_owner] : 1'b0;
        e_addr = e_en ? addr_i[m_owner*AW +: AW] : '0;
        e_rv   = (m_rv >= 0) ? NR'(1) << m_rv : '0;
        e_rd   = (m_rv >= 0) ? mem_data_i : '0;
        e_busy = (m_owner >= 0);
        e_err  = m_err;
      end
      n_chk++;
      if (gnt !== e_gnt) begin
        n_err++; $display("FAIL random gnt c%0d: got %b want %b", c, gnt, e_gnt);
      end
      n_chk++;
      if (mem_en !== e_en || mem_addr !== e_addr) begin
        n_err++; $display("FAIL random read c%0d: got en=%b addr=%h want en=%b addr=%h", c, mem_en, mem_addr, e_en, e_addr);
      end
      n_chk++;
      if (rvalid !== e_rv || rdata !== e_rd) begin
        n_err++; $display("FAIL random return c%0d: got rvalid=%b rdata=%h want rvalid=%b rdata=%h", c, rvalid, rdata, e_rv, e_rd);
      end
      n_chk++;
      if (busy !== e_busy || lock_err !== e_err) begin
        n_err++; $display("FAIL random status c%0d: got busy=%b err=%b want busy=%b err=%b", c, busy, lock_err, e_busy, e_err);
      end
      // Advance the model to the next cycle.
      if (reset) begin
        m_owner = -1; m_rr = 0; m_cnt = 0; m_rv = -1; m_err = 1'b0;
      end else begin
        m_rv  = e_en ? m_owner : -1;
        m_err = 1'b0;
        if (m_owner < 0) begin
          for (int i = 0; i < NR; i++) begin
            if (m_owner < 0 && req[(m_rr + i) % NR]) m_owner = (m_rr + i) % NR;
          end
          m_cnt = 0;
        end else begin
          held = req[m_owner] && lock[m_owner];
          to   = TO_EN && held && (m_cnt == LM - 1);
          if (!held || to) begin
            m_rr    = (m_owner + 1) % NR;
            m_owner = -1;
            m_err   = to;
          end else begin
            m_cnt++;
          end
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion within time limit want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_burst();
`ifdef ARB_LOCK_TIMEOUT_EN
    test_timeout();
`else
    test_lock_hold();
`endif
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inmem_rd_arbiter.md
INMEM_RD_ARBITER -- requirements
Module: inmem_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of requesters (0 = packet builder, 1 = DI checker, 2 = CRC checker).
REQ-002 Parameter ADDR_W, default 14, SHALL set the inmem word-address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the inmem read-data width.
REQ-004 Parameter LOCK_MAX, default 64, SHALL set the maximum number of cycles one owner may hold the port.
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 req  in  NUM_REQ  SHALL be the per-requester read request, held until granted.
REQ-008 lock  in  NUM_REQ  SHALL request that the port be kept for a multi-beat burst.
REQ-009 addr_i  in  NUM_REQ*ADDR_W  SHALL carry the per-requester read address; requester k occupies slice k.
REQ-010 gnt  out  NUM_REQ  SHALL be the one-hot owner indication.
REQ-011 rvalid  out  NUM_REQ  SHALL be a one-hot read-data-valid strobe.
REQ-012 rdata  out  DATA_W  SHALL be the shared read-data return.
REQ-013 mem_en  out  1  SHALL be the inmem port-B read enable.
REQ-014 mem_addr  out  ADDR_W  SHALL be the inmem port-B address.
REQ-015 mem_data_i  in  DATA_W  SHALL be the inmem port-B data, valid 1 cycle after mem_en.
REQ-016 busy  out  1  SHALL be high while the FSM is in OWNED.
REQ-017 lock_err  out  1  SHALL pulse high for 1 cycle on a forced lock release.

Function
REQ-018 The FSM SHALL have exactly two states: ARB_IDLE and ARB_OWNED.
REQ-019 In ARB_IDLE with any req bit high, the arbiter SHALL pick the first set req bit at or after rr_ptr (wrapping), store it as owner, and enter ARB_OWNED on the next cycle.
REQ-020 In ARB_OWNED, gnt SHALL equal onehot(owner), and in every cycle with req[owner] high: mem_en = 1, mem_addr = addr_i slice of owner.
REQ-021 In ARB_OWNED, a cycle with req[owner] = 0 SHALL issue no read and SHALL return the FSM to ARB_IDLE.
REQ-022 In ARB_OWNED, a cycle with req[owner] = 1 and lock[owner] = 0 SHALL issue that final read and then return the FSM to ARB_IDLE.
REQ-023 On every return to ARB_IDLE, rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-024 After each release, ARB_IDLE SHALL occupy exactly 1 cycle before the next grant; requests arriving simultaneously with a release SHALL wait for that cycle.
REQ-025 rvalid[k] SHALL be 1 exactly 1 cycle after a mem_en cycle issued for owner k.
REQ-026 rdata SHALL equal mem_data_i whenever any rvalid bit is high, and 0 otherwise.
REQ-027 The rvalid pipeline SHALL complete a final beat after release, even if a new owner has already been granted.
REQ-028 In ARB_IDLE, gnt = 0, mem_en = 0 and mem_addr = 0.
REQ-029 req/lock bits of non-owners SHALL be ignored while in ARB_OWNED.

Reset
REQ-030 While reset is high, the FSM SHALL go to ARB_IDLE and owner, rr_ptr, the lock counter, rvalid, lock_err, gnt, mem_en, mem_addr, rdata and busy SHALL all be 0.
REQ-031 Reset asserted mid-burst SHALL discard any in-flight rvalid.

Configuration
REQ-032 With ARB_LOCK_TIMEOUT_EN defined, a cycle counter SHALL count cycles spent in ARB_OWNED; in the cycle it reaches LOCK_MAX-1, the arbiter SHALL release the owner (that cycle's read still issues), pulse lock_err, and advance rr_ptr.
REQ-033 Without ARB_LOCK_TIMEOUT_EN, no counter SHALL exist, lock_err SHALL be tied to 0, and a lock SHALL be held indefinitely.

Structure
REQ-034 Package inmem_arb_pkg SHALL hold the state enum and the NUM_REQ/ADDR_W/DATA_W/LOCK_MAX defaults.
REQ-035 The round-robin pick SHALL be a combinational sub-module, rr_pick (inputs req and rr_ptr; outputs winner index and valid).

Verification
REQ-036 Single request: req=3'b010, lock=0, addr_i[1]=0x0040 -> gnt=3'b010 in cycle 1; mem_en=1 with mem_addr=0x0040 in cycle 1; rvalid=3'b010 with rdata=mem_data_i in cycle 2; gnt=0 in cycle 2.
REQ-037 Contention: req=3'b111 held, lock=0, rr_ptr=0 -> grants in order 0, 1, 2, 0, each separated by 1 idle cycle.
REQ-038 Burst: owner 0 with lock=1 for 5 cycles, then lock=0 -> 6 consecutive mem_en beats, and requester 2 is not granted until the cycle after the idle gap.
REQ-039 Timeout (macro defined, LOCK_MAX=8): lock[1] held for 20 cycles -> forced release after 8 OWNED cycles, lock_err high for 1 cycle, next grant goes to requester 2.
REQ-040 Reset mid-burst at beat 3 -> the following cycle has gnt=0, rvalid=0, mem_en=0, and the next grant starts from requester 0.
